// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one synchronous unified memory between several
// bus masters. It runs one transaction at a time and returns a per-master Done pulse.
module mem_bus_arbiter #(
  parameter int BusWidth    = 32,
  parameter int NUM_MASTERS = 2,
  localparam int ID_W       = $clog2(NUM_MASTERS)
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic [NUM_MASTERS-1:0]          Req,
  input  logic [NUM_MASTERS-1:0]          WE,
  input  logic [NUM_MASTERS*BusWidth-1:0] Addr,
  input  logic [NUM_MASTERS*BusWidth-1:0] WData,
  output logic [NUM_MASTERS-1:0]          Done,
  output logic [BusWidth-1:0]             RData,
  output logic [ID_W-1:0]                 Owner,
  output logic                            Busy,
  output logic                            MemWrite,
  output logic [BusWidth-1:0]             Address,
  output logic [BusWidth-1:0]             WriteData,
  input  logic [BusWidth-1:0]             ReadData,
  output logic [1:0]                      dbg_state
);

  // Handshake: a master holds Req, WE, Addr and WData steady until it sees
  // its Done bit, then drops Req on the edge that ends the Done cycle.
  // Inputs are latched at grant, so later changes are ignored. Req still
  // high in the following IDLE cycle counts as a new request.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state;
  logic            any_req;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] cand;

  assign dbg_state = state;

  // Owner doubles as the round-robin pointer. Scanning downward lets the
  // candidate nearest to Owner+1 be assigned last, so it wins.
  always_comb begin
    any_req = 1'b0;
    winner  = Owner;
    cand    = Owner;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      cand = ID_W'((int'(Owner) + k) % NUM_MASTERS);
      if (Req[cand]) begin
        any_req = 1'b1;
        winner  = cand;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      Done      <= '0;
      RData     <= '0;
      Owner     <= ID_W'(NUM_MASTERS - 1);
      Busy      <= 1'b0;
      MemWrite  <= 1'b0;
      Address   <= '0;
      WriteData <= '0;
    end else begin
      Done <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= ACCESS;
            Busy      <= 1'b1;
            Owner     <= winner;
            MemWrite  <= WE[winner];
            Address   <= Addr[int'(winner)*BusWidth +: BusWidth];
            WriteData <= WData[int'(winner)*BusWidth +: BusWidth];
          end
        end
        ACCESS: begin
          // MemWrite still carries the latched WE during this cycle.
          MemWrite <= 1'b0;
          if (MemWrite) begin
            state       <= DONE;
            Done[Owner] <= 1'b1;
          end else begin
            state <= RDWAIT;
          end
        end
        RDWAIT: begin
          RData       <= ReadData;
          Done[Owner] <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always @(posedge CLK) begin
    if (!RESET) assert (!$isunknown(Req));
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a 2-master instance with a synchronous
// memory model, and a 4-master instance for rotation and dropped-request cases.
module tb_mem_bus_arbiter;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;

  // ---------------- 2-master instance ----------------
  logic        rst2;
  logic [1:0]  req2, we2, done2;
  logic [63:0] addr2, wdata2;
  logic [31:0] rdata2, address2, writedata2, readdata2;
  logic [0:0]  owner2;
  logic        busy2, memwrite2;
  logic [1:0]  dbg2;

  mem_bus_arbiter #(.BusWidth(32), .NUM_MASTERS(2)) u_dut2 (
    .CLK(CLK), .RESET(rst2), .Req(req2), .WE(we2), .Addr(addr2), .WData(wdata2),
    .Done(done2), .RData(rdata2), .Owner(owner2), .Busy(busy2),
    .MemWrite(memwrite2), .Address(address2), .WriteData(writedata2),
    .ReadData(readdata2), .dbg_state(dbg2)
  );

  // Synchronous word memory plus a bench-side preload port.
  logic [31:0] mem [0:255];
  logic        pre_we;
  logic [7:0]  pre_idx;
  logic [31:0] pre_data;
  always @(posedge CLK) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (memwrite2) mem[address2[9:2]] <= writedata2;
    readdata2 <= mem[address2[9:2]];
  end

  // ---------------- 4-master instance ----------------
  logic         rst4;
  logic [3:0]   req4, we4, done4;
  logic [127:0] addr4, wdata4;
  logic [31:0]  rdata4, address4, writedata4, readdata4;
  logic [1:0]   owner4;
  logic         busy4, memwrite4;
  logic [1:0]   dbg4;

  assign readdata4 = 32'h0;

  mem_bus_arbiter #(.BusWidth(32), .NUM_MASTERS(4)) u_dut4 (
    .CLK(CLK), .RESET(rst4), .Req(req4), .WE(we4), .Addr(addr4), .WData(wdata4),
    .Done(done4), .RData(rdata4), .Owner(owner4), .Busy(busy4),
    .MemWrite(memwrite4), .Address(address4), .WriteData(writedata4),
    .ReadData(readdata4), .dbg_state(dbg4)
  );

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction on the 2-master instance, starting from IDLE.
  task automatic txn2(input string tag, input int owner, input bit is_write,
                      input logic [31:0] addr, input logic [31:0] exp_rdata);
    logic [31:0] onehot;
    onehot = 32'd1 << owner;
    tick();
    check({tag, ".owner"}, 32'(owner2), 32'(owner));
    check({tag, ".busy"}, 32'(busy2), 32'd1);
    check({tag, ".addr"}, address2, addr);
    check({tag, ".mw"}, 32'(memwrite2), 32'(is_write));
    check({tag, ".done_early"}, 32'(done2), 32'd0);
    tick();
    if (!is_write) begin
      check({tag, ".rdwait_done"}, 32'(done2), 32'd0);
      check({tag, ".rdwait_mw"}, 32'(memwrite2), 32'd0);
      tick();
      check({tag, ".rdata"}, rdata2, exp_rdata);
    end
    check({tag, ".done"}, 32'(done2), onehot);
    check({tag, ".done_mw"}, 32'(memwrite2), 32'd0);
    tick();
    check({tag, ".idle_done"}, 32'(done2), 32'd0);
    check({tag, ".idle_busy"}, 32'(busy2), 32'd0);
  endtask

  // One write transaction on the 4-master instance, starting from IDLE.
  task automatic txn4(input string tag, input int owner);
    tick();
    check({tag, ".owner"}, 32'(owner4), 32'(owner));
    check({tag, ".mw"}, 32'(memwrite4), 32'd1);
    check({tag, ".done_early"}, 32'(done4), 32'd0);
    tick();
    check({tag, ".done"}, 32'(done4), 32'd1 << owner);
    tick();
    check({tag, ".idle_done"}, 32'(done4), 32'd0);
    check({tag, ".idle_busy"}, 32'(busy4), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst2 = 1'b1; req2 = '0; we2 = '0; addr2 = '0; wdata2 = '0;
    rst4 = 1'b1; req4 = '0; we4 = '0; addr4 = '0; wdata4 = '0;
    pre_we = 1'b0; pre_idx = '0; pre_data = '0;
    tick(); tick();

    // Reset values
    check("rst.done", 32'(done2), 32'd0);
    check("rst.rdata", rdata2, 32'd0);
    check("rst.owner", 32'(owner2), 32'd1);
    check("rst.busy", 32'(busy2), 32'd0);
    check("rst.mw", 32'(memwrite2), 32'd0);
    check("rst.addr", address2, 32'd0);
    check("rst.wdata", writedata2, 32'd0);
    check("rst.state", 32'(dbg2), 32'd0);
    rst2 = 1'b0;

    // Master 0 writes 7 to address 100
    req2 = 2'b01; we2 = 2'b01; addr2[31:0] = 32'd100; wdata2[31:0] = 32'd7;
    tick();
    check("wr.mw", 32'(memwrite2), 32'd1);
    check("wr.addr", address2, 32'd100);
    check("wr.wdata", writedata2, 32'd7);
    check("wr.busy1", 32'(busy2), 32'd1);
    check("wr.owner", 32'(owner2), 32'd0);
    check("wr.done_early", 32'(done2), 32'd0);
    tick();
    check("wr.done", 32'(done2), 32'b01);
    check("wr.mw_low", 32'(memwrite2), 32'd0);
    check("wr.busy2", 32'(busy2), 32'd1);
    req2 = 2'b00;
    tick();
    check("wr.done_off", 32'(done2), 32'd0);
    check("wr.busy_off", 32'(busy2), 32'd0);
    check("wr.mem", mem[25], 32'd7);

    // Master 1 reads preloaded 0xDEADBEEF at 0x20
    pre_we = 1'b1; pre_idx = 8'd8; pre_data = 32'hDEADBEEF;
    tick();
    pre_idx = 8'd16; pre_data = 32'h11112222;
    tick();
    pre_idx = 8'd17; pre_data = 32'h33334444;
    tick();
    pre_we = 1'b0;
    req2 = 2'b10; we2 = 2'b00; addr2[63:32] = 32'h20;
    txn2("rd", 1, 1'b0, 32'h20, 32'hDEADBEEF);
    req2 = 2'b00;
    tick();
    check("rd.rdata_hold", rdata2, 32'hDEADBEEF);

    // Address change after grant is ignored
    req2 = 2'b10; addr2[63:32] = 32'h40;
    tick();
    check("chg.addr_grant", address2, 32'h40);
    addr2[63:32] = 32'h44;
    tick();
    check("chg.addr_rdwait", address2, 32'h40);
    tick();
    check("chg.done", 32'(done2), 32'b10);
    check("chg.rdata", rdata2, 32'h11112222);
    req2 = 2'b00;
    tick();

    // Both masters request continuously from reset: order 0,1,0,1
    rst2 = 1'b1;
    req2 = 2'b11; we2 = 2'b01;
    addr2 = {32'h20, 32'h80}; wdata2 = {32'h0, 32'hA5};
    tick(); tick();
    check("rr.rst_busy", 32'(busy2), 32'd0);
    check("rr.rst_owner", 32'(owner2), 32'd1);
    rst2 = 1'b0;
    txn2("rr0", 0, 1'b1, 32'h80, 32'h0);
    txn2("rr1", 1, 1'b0, 32'h20, 32'hDEADBEEF);
    txn2("rr2", 0, 1'b1, 32'h80, 32'h0);
    txn2("rr3", 1, 1'b0, 32'h20, 32'hDEADBEEF);
    check("rr.mem", mem[32], 32'hA5);

    // Reset during RDWAIT aborts the read; first grant afterwards is master 0
    req2 = 2'b10;
    tick();
    check("abort.owner", 32'(owner2), 32'd1);
    tick();
    check("abort.rdwait", 32'(dbg2), 32'd2);
    rst2 = 1'b1;
    tick();
    check("abort.busy", 32'(busy2), 32'd0);
    check("abort.done", 32'(done2), 32'd0);
    check("abort.mw", 32'(memwrite2), 32'd0);
    check("abort.rdata", rdata2, 32'd0);
    check("abort.owner_rst", 32'(owner2), 32'd1);
    req2 = 2'b11; rst2 = 1'b0;
    tick();
    check("abort.regrant", 32'(owner2), 32'd0);
    check("abort.regrant_mw", 32'(memwrite2), 32'd1);
    tick();
    check("abort.regrant_done", 32'(done2), 32'b01);
    req2 = 2'b00;
    tick();

    // Four masters: 0,1,2,3,0 then master 2 drops out: 1,3,0
    req4 = 4'b1111; we4 = 4'b1111;
    addr4 = {32'h30, 32'h20, 32'h10, 32'h00};
    tick();
    rst4 = 1'b0;
    txn4("q0", 0);
    txn4("q1", 1);
    txn4("q2", 2);
    txn4("q3", 3);
    txn4("q4", 0);
    req4 = 4'b1011;
    txn4("q5", 1);
    txn4("q6", 3);
    txn4("q7", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
